// File: rtl/parking_spot_allocator_pkg.sv
// Shared sizing defaults and entry-FSM state encodings for the parking spot allocator.
package parking_spot_allocator_pkg;

  localparam int NUM_SPOTS   = 8;
  localparam int SPOT_W      = 3;
  localparam int CNT_W       = 4;
  localparam int GATE_CYCLES = 4;
  localparam int GATE_CNT_W  = $clog2(GATE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE     = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

endpackage

// File: rtl/parking_spot_allocator_free_spot_finder.sv
// Priority encoder: reports the lowest-index set bit of the free-spot vector.
module free_spot_finder
  import parking_spot_allocator_pkg::*;
#(
  parameter int N_SPOTS = NUM_SPOTS,
  parameter int IDX_W   = SPOT_W
) (
  input  logic [N_SPOTS-1:0] free_vec,
  output logic [IDX_W-1:0]   free_idx,
  output logic               any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_spot_allocator.sv
// Owns the parking occupancy vector: allocates the lowest free spot on entry,
// releases named spots on exit, and drives the timed entry gate.
module parking_spot_allocator
  import parking_spot_allocator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SPOT_W-1:0]    exit_spot,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     parked,
  output logic                 full,
  output logic                 empty,
  output logic                 entry_ack,
  output logic [SPOT_W-1:0]    entry_spot,
  output logic                 entry_reject,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic                 gate_open
);

  state_e                  state_q, state_d;
  logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [NUM_SPOTS-1:0]    occupancy_q, occupancy_d;
  logic [CNT_W-1:0]        parked_q, parked_d;
  logic                    entry_ack_q, entry_ack_d;
  logic [SPOT_W-1:0]       entry_spot_q, entry_spot_d;
  logic                    entry_reject_q, entry_reject_d;
  logic                    exit_ack_q, exit_ack_d;
  logic                    exit_err_q, exit_err_d;

  logic [SPOT_W-1:0]       free_idx;
  logic                    any_free;
  logic                    full_w;
  logic                    alloc;
  logic                    reject;
  logic                    exit_hit;
  logic [NUM_SPOTS-1:0]    exit_clr;

  // Allocation looks only at pre-edge occupancy, so a spot freed this cycle is not reused yet.
  free_spot_finder #(
    .N_SPOTS (NUM_SPOTS),
    .IDX_W   (SPOT_W)
  ) u_finder (
    .free_vec (~occupancy_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign full_w = (parked_q == CNT_W'(NUM_SPOTS));
  assign alloc  = (state_q == ST_IDLE) && entry_req && !full_w && any_free;
  assign reject = (state_q == ST_IDLE) && entry_req && full_w;

  // Out-of-range exit indices match no bit and therefore read as free.
  always_comb begin
    exit_hit = 1'b0;
    exit_clr = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (exit_req && (exit_spot == SPOT_W'(i)) && occupancy_q[i]) begin
        exit_hit    = 1'b1;
        exit_clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    occupancy_d    = occupancy_q & ~exit_clr;
    parked_d       = parked_q;
    entry_ack_d    = alloc;
    entry_spot_d   = entry_spot_q;
    entry_reject_d = reject;
    exit_ack_d     = exit_hit;
    exit_err_d     = exit_req && !exit_hit;

    if (alloc) begin
      occupancy_d  = occupancy_d | (NUM_SPOTS'(1) << free_idx);
      entry_spot_d = free_idx;
    end

    case ({alloc, exit_hit})
      2'b10:   parked_d = parked_q + CNT_W'(1);
      2'b01:   parked_d = parked_q - CNT_W'(1);
      default: parked_d = parked_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (alloc) begin
          state_d    = ST_GATE;
          gate_cnt_d = GATE_CNT_W'(GATE_CYCLES);
        end else if (reject) begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_GATE: begin
        if (gate_cnt_q == GATE_CNT_W'(1)) begin
          state_d    = ST_WAIT_CLR;
          gate_cnt_d = '0;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_CNT_W'(1);
        end
      end
      ST_WAIT_CLR: begin
        if (!entry_req) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        gate_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gate_cnt_q     <= '0;
      occupancy_q    <= '0;
      parked_q       <= '0;
      entry_ack_q    <= 1'b0;
      entry_spot_q   <= '0;
      entry_reject_q <= 1'b0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      occupancy_q    <= occupancy_d;
      parked_q       <= parked_d;
      entry_ack_q    <= entry_ack_d;
      entry_spot_q   <= entry_spot_d;
      entry_reject_q <= entry_reject_d;
      exit_ack_q     <= exit_ack_d;
      exit_err_q     <= exit_err_d;
    end
  end

  assign occupancy    = occupancy_q;
  assign parked       = parked_q;
  assign full         = full_w;
  assign empty        = (parked_q == '0);
  assign entry_ack    = entry_ack_q;
  assign entry_spot   = entry_spot_q;
  assign entry_reject = entry_reject_q;
  assign exit_ack     = exit_ack_q;
  assign exit_err     = exit_err_q;
  assign gate_open    = (state_q == ST_GATE);

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Directed scoreboard bench for parking_spot_allocator: expected responses are
// queued by the stimulus and popped by a monitor whenever the DUT pulses.
module tb_parking_spot_allocator;

  logic       clk;
  logic       rst;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_spot;
  logic [7:0] occupancy;
  logic [3:0] parked;
  logic       full;
  logic       empty;
  logic       entry_ack;
  logic [2:0] entry_spot;
  logic       entry_reject;
  logic       exit_ack;
  logic       exit_err;
  logic       gate_open;

  typedef struct packed {
    logic       ack;
    logic [2:0] spot;
    logic       rej;
    logic       xack;
    logic       xerr;
    logic [7:0] occ;
    logic [3:0] parked;
    logic       full;
    logic       empty;
  } resp_t;

  resp_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    gate_cycles = 0;

  parking_spot_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .exit_spot    (exit_spot),
    .occupancy    (occupancy),
    .parked       (parked),
    .full         (full),
    .empty        (empty),
    .entry_ack    (entry_ack),
    .entry_spot   (entry_spot),
    .entry_reject (entry_reject),
    .exit_ack     (exit_ack),
    .exit_err     (exit_err),
    .gate_open    (gate_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every pulse cycle must match the oldest queued expectation.
  initial begin
    resp_t act, expv;
    forever begin
      @(negedge clk);
      if (gate_open) gate_cycles++;
      if (entry_ack || entry_reject || exit_ack || exit_err) begin
        act = '{ack: entry_ack, spot: entry_spot, rej: entry_reject, xack: exit_ack,
                xerr: exit_err, occ: occupancy, parked: parked, full: full, empty: empty};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_pulse at %0t: got %h, none expected", $time, act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL response at %0t: got ack=%b spot=%0d rej=%b xack=%b xerr=%b occ=%h parked=%0d full=%b empty=%b, want ack=%b spot=%0d rej=%b xack=%b xerr=%b occ=%h parked=%0d full=%b empty=%b",
                     $time, act.ack, act.spot, act.rej, act.xack, act.xerr, act.occ, act.parked, act.full, act.empty,
                     expv.ack, expv.spot, expv.rej, expv.xack, expv.xerr, expv.occ, expv.parked, expv.full, expv.empty);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic ack, input logic [2:0] spot, input logic rej,
                         input logic xack, input logic xerr, input logic [7:0] occ,
                         input logic [3:0] pk);
    resp_t r;
    r = '{ack: ack, spot: spot, rej: rej, xack: xack, xerr: xerr, occ: occ,
          parked: pk, full: (pk == 4'd8), empty: (pk == 4'd0)};
    exp_q.push_back(r);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Drives one cycle of requests, then releases them.
  task automatic applyStimulus(input logic ent, input logic ex, input logic [2:0] spot, input int settle);
    entry_req = ent;
    exit_req  = ex;
    exit_spot = spot;
    tick(1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_spot = 3'd0;
    tick(settle);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic fillLot(input int n);
    for (int i = 0; i < n; i++) begin
      pushExp(1'b1, 3'(i), 1'b0, 1'b0, 1'b0, 8'((16'h1 << (i + 1)) - 1), 4'(i + 1));
      applyStimulus(1'b1, 1'b0, 3'd0, 6);
    end
  endtask

  initial begin
    rst       = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_spot = 3'd0;
    tick(2);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_occupancy", 32'(occupancy), 32'h00);
    checkOutput("reset_parked", 32'(parked), 32'd0);
    checkOutput("reset_flags", {30'd0, full, empty}, 32'b01);
    checkOutput("reset_gate", 32'(gate_open), 32'd0);

    $display("[TB] held entry request");
    gate_cycles = 0;
    pushExp(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h01, 4'd1);
    entry_req = 1'b1;
    tick(10);
    entry_req = 1'b0;
    tick(2);
    checkOutput("held_gate_cycles", 32'(gate_cycles), 32'd4);
    checkOutput("held_occupancy", 32'(occupancy), 32'h01);

    $display("[TB] fill lot and reject");
    doReset();
    fillLot(8);
    checkOutput("filled_state", {20'd0, occupancy, parked}, {20'd0, 8'hFF, 4'd8});
    checkOutput("filled_full", 32'(full), 32'd1);
    pushExp(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd8);
    applyStimulus(1'b1, 1'b0, 3'd0, 6);
    checkOutput("reject_occupancy", 32'(occupancy), 32'hFF);

    $display("[TB] exit then reuse");
    doReset();
    fillLot(4);
    pushExp(1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'h0B, 4'd3);
    applyStimulus(1'b0, 1'b1, 3'd2, 1);
    pushExp(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h0F, 4'd4);
    applyStimulus(1'b1, 1'b0, 3'd0, 6);

    $display("[TB] exit of free spots");
    pushExp(1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 8'h0B, 4'd3);
    applyStimulus(1'b0, 1'b1, 3'd2, 1);
    pushExp(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd3);
    applyStimulus(1'b0, 1'b1, 3'd5, 1);
    pushExp(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h0B, 4'd3);
    applyStimulus(1'b0, 1'b1, 3'd2, 1);

    $display("[TB] full lot with simultaneous exit");
    doReset();
    fillLot(8);
    pushExp(1'b0, 3'd7, 1'b1, 1'b1, 1'b0, 8'h7F, 4'd7);
    applyStimulus(1'b1, 1'b1, 3'd7, 6);
    checkOutput("simul_full_flag", 32'(full), 32'd0);

    $display("[TB] simultaneous allocate and exit, then reset in gate");
    doReset();
    fillLot(2);
    pushExp(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h06, 4'd2);
    applyStimulus(1'b1, 1'b1, 3'd0, 1);
    checkOutput("gate_before_reset", 32'(gate_open), 32'd1);
    doReset();
    checkOutput("midgate_occupancy", 32'(occupancy), 32'h00);
    checkOutput("midgate_parked_flags", {26'd0, parked, full, empty}, {26'd0, 4'd0, 1'b0, 1'b1});
    checkOutput("midgate_gate", 32'(gate_open), 32'd0);
    checkOutput("midgate_spot_pulses",
                {27'd0, entry_spot, entry_ack | entry_reject | exit_ack | exit_err}, 32'd0);

    tick(2);
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
